// File: rtl/servo_pkg.sv
// Constants and types shared by the servo bin sequencer
// and the servo PWM generator.
package servo_pkg;

  localparam int unsigned SERVO_BIN_W      = 4;
  localparam int unsigned SERVO_MAX_BIN    = 8;
  localparam int unsigned PWM_FRAME_CYCLES = 1_966_080;

  typedef enum logic {
    IDLE = 1'b0,
    MOVE = 1'b1
  } servo_state_e;

endpackage

// File: rtl/servo_bin_sequencer.sv
// Slews the PWM bin one step per dwell period toward
// the most recently accepted target angle bin.
module servo_bin_sequencer
  import servo_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = PWM_FRAME_CYCLES,
  parameter int unsigned MAX_BIN     = SERVO_MAX_BIN
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [SERVO_BIN_W-1:0] target_in,
  input  logic                   target_valid_in,
  output logic                   target_ready_out,
  output logic [SERVO_BIN_W-1:0] bin_out,
  output logic                   moving_out,
  output logic                   arrived_out
);

  localparam int unsigned TW =
    (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned LAST_I = STEP_CYCLES - 1;
  localparam logic [TW-1:0] LAST = LAST_I[TW-1:0];
  localparam logic [TW-1:0] T_ONE = 1;
  localparam logic [SERVO_BIN_W-1:0] MAX_B =
    MAX_BIN[SERVO_BIN_W-1:0];
  localparam logic [SERVO_BIN_W-1:0] B_ONE = 1;

  servo_state_e           state_q, state_d;
  logic [SERVO_BIN_W-1:0] bin_q, bin_d;
  logic [SERVO_BIN_W-1:0] tgt_q, tgt_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   moving_q, moving_d;
  logic                   arrived_q, arrived_d;
  logic                   ready_q, ready_d;

  logic                   accept;
  logic [SERVO_BIN_W-1:0] clamped;
  logic [SERVO_BIN_W-1:0] eff_t;
  logic [SERVO_BIN_W-1:0] next_bin;

  always_comb begin
    accept   = target_valid_in && ready_q;
    clamped  = (target_in > MAX_B) ? MAX_B : target_in;
    eff_t    = accept ? clamped : tgt_q;
    // Direction is taken from eff_t, so a boundary retarget wins.
    next_bin = (eff_t > bin_q) ? bin_q + B_ONE
                               : bin_q - B_ONE;

    state_d   = state_q;
    bin_d     = bin_q;
    tgt_d     = eff_t;
    timer_d   = timer_q;
    moving_d  = moving_q;
    arrived_d = 1'b0;
    ready_d   = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (eff_t != bin_q) begin
            state_d  = MOVE;
            timer_d  = '0;
            moving_d = 1'b1;
          end else begin
            arrived_d = 1'b1;
          end
        end
      end
      MOVE: begin
        if (eff_t == bin_q) begin
          state_d   = IDLE;
          timer_d   = '0;
          moving_d  = 1'b0;
          arrived_d = 1'b1;
        end else if (timer_q == LAST) begin
          bin_d   = next_bin;
          timer_d = '0;
          if (next_bin == eff_t) begin
            state_d   = IDLE;
            moving_d  = 1'b0;
            arrived_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      tgt_q     <= '0;
      timer_q   <= '0;
      moving_q  <= 1'b0;
      arrived_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      tgt_q     <= tgt_d;
      timer_q   <= timer_d;
      moving_q  <= moving_d;
      arrived_q <= arrived_d;
      ready_q   <= ready_d;
    end
  end

  assign target_ready_out = ready_q;
  assign bin_out          = bin_q;
  assign moving_out       = moving_q;
  assign arrived_out      = arrived_q;

endmodule

// File: tb/tb_servo_bin_sequencer.sv
// Directed and randomized checks of servo_bin_sequencer
// with a short dwell of four cycles per bin.
module tb_servo_bin_sequencer;

  localparam int STEP = 4;
  localparam int MAXB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] tin = '0;
  logic       valid = 1'b0;
  logic       ready;
  logic [3:0] bin;
  logic       moving;
  logic       arrived;

  int n_checks = 0;
  int n_fail = 0;

  int m_bin = 0;
  int m_tgt = 0;
  int m_ph = 0;
  int m_arr = 0;
  int m_ready = 0;

  servo_bin_sequencer #(
    .STEP_CYCLES(STEP),
    .MAX_BIN(MAXB)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .target_in(tin),
    .target_valid_in(valid),
    .target_ready_out(ready),
    .bin_out(bin),
    .moving_out(moving),
    .arrived_out(arrived)
  );

  always #5 clk = ~clk;

  // Behavioural reference: position, target and elapsed dwell.
  always @(posedge clk) begin
    int eff;
    bit acc;
    if (rst) begin
      m_bin = 0; m_tgt = 0; m_ph = 0;
      m_arr = 0; m_ready = 0;
    end else begin
      acc = valid && (m_ready != 0);
      eff = acc ? ((int'(tin) > MAXB) ? MAXB : int'(tin))
                : m_tgt;
      m_arr = 0;
      if (m_bin == eff) begin
        m_arr = (acc || m_bin != m_tgt) ? 1 : 0;
        m_ph = 0;
      end else if (m_bin == m_tgt) begin
        m_ph = 0;
      end else if (m_ph == STEP - 1) begin
        m_bin = m_bin + ((eff > m_bin) ? 1 : -1);
        m_ph = 0;
        m_arr = (m_bin == eff) ? 1 : 0;
      end else begin
        m_ph = m_ph + 1;
      end
      m_tgt = eff;
      m_ready = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input int t);
    tin = 4'(t);
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({ready, bin, moving, arrived} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_vals: got rdy=%b bin=%0d mov=%b arr=%b want all 0",
               ready, bin, moving, arrived);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", ready);
    end
  endtask

  task automatic test_basic();
    int eb;
    do_reset();
    send(3);
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) tick();
      eb = (k / STEP > 3) ? 3 : k / STEP;
      n_checks++;
      if (bin !== 4'(eb) || moving !== (k < 12) ||
          arrived !== (k == 12)) begin
        n_fail++;
        $display("FAIL basic k=%0d: got bin=%0d mov=%b arr=%b want bin=%0d mov=%b arr=%b",
                 k, bin, moving, arrived, eb, k < 12, k == 12);
      end
    end
  endtask

  task automatic test_clamp();
    do_reset();
    send(15);
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (bin > 4'(MAXB)) begin
        n_fail++;
        $display("FAIL clamp_range k=%0d: got %0d want <=8", k, bin);
      end
      if (k == 31 || k == 32) begin
        n_checks++;
        if (bin !== 4'(k / STEP) || arrived !== (k == 32)) begin
          n_fail++;
          $display("FAIL clamp_arrive k=%0d: got bin=%0d arr=%b want bin=%0d arr=%b",
                   k, bin, arrived, k / STEP, k == 32);
        end
      end
    end
  endtask

  task automatic test_retarget();
    do_reset();
    send(6);
    repeat (12) tick();
    n_checks++;
    if (bin !== 4'd3) begin
      n_fail++;
      $display("FAIL retarget_b3: got %0d want 3", bin);
    end
    repeat (2) tick();
    send(1);
    tick();
    n_checks++;
    if (bin !== 4'd2 || moving !== 1'b1) begin
      n_fail++;
      $display("FAIL retarget_b2: got bin=%0d mov=%b want 2 1", bin, moving);
    end
    repeat (3) tick();
    n_checks++;
    if (bin !== 4'd2) begin
      n_fail++;
      $display("FAIL retarget_hold: got %0d want 2", bin);
    end
    tick();
    n_checks++;
    if (bin !== 4'd1 || arrived !== 1'b1 || moving !== 1'b0) begin
      n_fail++;
      $display("FAIL retarget_b1: got bin=%0d arr=%b mov=%b want 1 1 0",
               bin, arrived, moving);
    end
  endtask

  task automatic test_same_bin();
    do_reset();
    send(2);
    repeat (9) tick();
    send(2);
    n_checks++;
    if (bin !== 4'd2 || arrived !== 1'b1 || moving !== 1'b0) begin
      n_fail++;
      $display("FAIL same_idle: got bin=%0d arr=%b mov=%b want 2 1 0",
               bin, arrived, moving);
    end
    tick();
    n_checks++;
    if (arrived !== 1'b0 || moving !== 1'b0) begin
      n_fail++;
      $display("FAIL same_idle_pulse: got arr=%b mov=%b want 0 0",
               arrived, moving);
    end
    send(5);
    repeat (6) tick();
    send(3);
    n_checks++;
    if (bin !== 4'd3 || arrived !== 1'b1 || moving !== 1'b0) begin
      n_fail++;
      $display("FAIL same_move: got bin=%0d arr=%b mov=%b want 3 1 0",
               bin, arrived, moving);
    end
    repeat (5) tick();
    n_checks++;
    if (bin !== 4'd3 || arrived !== 1'b0) begin
      n_fail++;
      $display("FAIL same_move_hold: got bin=%0d arr=%b want 3 0",
               bin, arrived);
    end
  endtask

  task automatic test_reverse();
    do_reset();
    send(7);
    repeat (16) tick();
    n_checks++;
    if (bin !== 4'd4) begin
      n_fail++;
      $display("FAIL reverse_b4: got %0d want 4", bin);
    end
    repeat (3) tick();
    send(0);
    n_checks++;
    if (bin !== 4'd3 || moving !== 1'b1) begin
      n_fail++;
      $display("FAIL reverse_dir: got bin=%0d mov=%b want 3 1", bin, moving);
    end
    repeat (12) tick();
    n_checks++;
    if (bin !== 4'd0 || arrived !== 1'b1) begin
      n_fail++;
      $display("FAIL reverse_end: got bin=%0d arr=%b want 0 1", bin, arrived);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(8);
    repeat (20) tick();
    n_checks++;
    if (bin !== 4'd5) begin
      n_fail++;
      $display("FAIL rstmid_b5: got %0d want 5", bin);
    end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({ready, bin, moving, arrived} !== 7'b0) begin
      n_fail++;
      $display("FAIL rstmid_vals: got rdy=%b bin=%0d mov=%b arr=%b want all 0",
               ready, bin, moving, arrived);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (ready !== 1'b1 || bin !== 4'd0 || moving !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after: got rdy=%b bin=%0d mov=%b want 1 0 0",
               ready, bin, moving);
    end
  endtask

  task automatic test_random();
    bit em;
    for (int c = 0; c < 3000; c++) begin
      em = (m_bin != m_tgt);
      n_checks++;
      if (int'(bin) != m_bin || moving !== em ||
          int'(arrived) != m_arr || int'(ready) != m_ready ||
          (moving && arrived)) begin
        n_fail++;
        $display("FAIL random c=%0d: got bin=%0d mov=%b arr=%b rdy=%b want %0d %b %0d %0d",
                 c, bin, moving, arrived, ready, m_bin, em, m_arr, m_ready);
      end
      valid = ($urandom_range(0, 5) == 0);
      tin = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;
    valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_retarget();
    test_same_bin();
    test_reverse();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/servo_bin_sequencer.md
Name: servo_bin_sequencer

Overview:
- Upstream stage of the servo PWM generator. Accepts requested target angle bins (0..8, pi/8 radians per bin) over a valid/ready handshake and drives the 4-bit bin input of the PWM generator.
- Slews one bin at a time, holding each intermediate bin for a programmable dwell time, so the servo never jumps across its full range in one PWM frame.
- Reports motion status and arrival to the control logic that issues the targets.

Parameters:
- STEP_CYCLES, 1_966_080, dwell per bin in clk_in cycles (one 50 Hz PWM frame at 98.304 MHz); must be at least 1.
- MAX_BIN, 8, highest legal bin (180 degrees); requests above it are clamped.

Ports:
- clk_in  input  1  system clock, 98.304 MHz.
- rst_in  input  1  synchronous reset, active-high.
- target_in  input  4  requested bin.
- target_valid_in  input  1  target_in is valid this cycle.
- target_ready_out  output  1  sequencer can accept a target.
- bin_out  output  4  current bin, fed to the PWM generator's bin input.
- moving_out  output  1  high while bin_out differs from the active target.
- arrived_out  output  1  one-cycle pulse when bin_out reaches the target.

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_in is synchronous and active-high.
- Reset values: bin_out=0, target register=0, state=IDLE, step timer=0, moving_out=0, arrived_out=0, target_ready_out=0.
- target_ready_out is 1 in every cycle after the reset cycle. Reset asserted mid-move returns everything to the reset values on the next edge; no step is taken.
- Accept: occurs when target_valid_in && target_ready_out. The accepted value is clamped to min(target_in, MAX_BIN). The effective target eff_t is the clamped value on an accept cycle, otherwise the target register. The target register loads eff_t on every accept.
- States: IDLE and MOVE. All outputs are registered.
- IDLE, accept with eff_t != bin_out: go to MOVE, timer=0, moving_out=1 from the next cycle. bin_out does not change yet.
- IDLE, accept with eff_t == bin_out: stay in IDLE, arrived_out=1 for one cycle on the next cycle.
- MOVE, each cycle:
  - if eff_t == bin_out (retarget onto the current bin): go to IDLE, timer=0, moving_out=0, arrived_out pulse.
  - else if timer == STEP_CYCLES-1: bin_out steps by +1 if eff_t > bin_out, otherwise by -1; timer=0. If the new bin_out == eff_t, go to IDLE, moving_out=0, arrived_out pulse in that same registered update.
  - else: timer increments.
- Retarget during MOVE does not restart the timer. Direction is re-evaluated at every step boundary from eff_t, so an accept on the boundary cycle is honoured immediately.
- Latency: the first step appears on bin_out STEP_CYCLES cycles after the accept edge. A move of N bins completes N*STEP_CYCLES cycles after the accept.
- Arithmetic:
  - bin_out stays within 0..MAX_BIN and never wraps; the direction logic guarantees this.
  - Timer width is $clog2(STEP_CYCLES), with a minimum of 1 bit.
  - Compare timer == STEP_CYCLES-1 at the timer's width. When STEP_CYCLES=1 the sequencer steps every cycle.
- arrived_out never lasts more than one cycle. moving_out and arrived_out are never high together.

Decomposition:
- Package servo_pkg holds:
  - SERVO_BIN_W=4
  - SERVO_MAX_BIN=8
  - PWM_FRAME_CYCLES=1_966_080
  - the state enum typedef {IDLE, MOVE}
- The PWM generator and this block share these constants.
- No sub-module. The step timer is inline: a single counter and FSM, roughly 150 lines.

Test Plan (STEP_CYCLES=4):
- Reset, then target 3 accepted at cycle t: bin_out=1,2,3 at t+4, t+8, t+12. moving_out is high from t+1 to t+11; arrived_out pulses exactly at t+12; moving_out=0 from t+12.
- Target 15 from bin 0: clamped to 8. bin_out reaches 8 after 32 cycles and never exceeds 8.
- Moving 0->6, at bin 3 accept target 1 two cycles into the dwell: the timer is not restarted, bin_out becomes 2 two cycles later, then 1 after 4 more cycles; then arrived_out pulses.
- At bin 2, accept target 2 in IDLE: bin_out is unchanged, one arrived_out pulse, moving_out stays 0. Mid-move, accept a target equal to the current bin: IDLE on the next cycle with an arrived_out pulse.
- Accept on the exact step-boundary cycle reversing direction (at bin 4 heading to 7, new target 0): bin_out goes to 3, not 5.
- rst_in asserted mid-move at bin 5: next cycle bin_out=0, moving_out=0, arrived_out=0, target_ready_out=0, then 1 the following cycle.
